// File: rtl/video_timing_checker.sv
// Video timing checker: follows an hsync/vsync/de stream through one frame
// template, flags the first timing violation it sees, reports clean frames
// and the pixel sum of the most recent clean frame.
module video_timing_checker #(
    parameter int H_VISIBLE     = 1024,
    parameter int H_FP          = 24,
    parameter int H_SYNC        = 136,
    parameter int H_BP          = 160,
    parameter int V_VISIBLE     = 768,
    parameter int V_FP          = 3,
    parameter int V_SYNC        = 6,
    parameter int V_BP          = 29,
    parameter int SYNC_POLARITY = 0,
    parameter int PIXEL_WIDTH   = 24,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hsync,
    input  logic                     vsync,
    input  logic                     de,
    input  logic [PIXEL_WIDTH-1:0]   pixel,
    input  logic                     err_clear,
    output logic                     locked,
    output logic                     frame_done,
    output logic [31:0]              frame_count,
    output logic [31:0]              frame_checksum,
    output logic [7:0]               err_flags,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [2:0]               o_dbg_state
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int RUN_W   = $clog2(V_TOTAL * H_TOTAL + 1);
    localparam int LINE_W  = $clog2(V_VISIBLE + 1);

    // Required number of cycles spent in each state before its exit event.
    localparam logic [RUN_W-1:0] LEN_VSYNC = RUN_W'(V_SYNC * H_TOTAL);
    localparam logic [RUN_W-1:0] LEN_VBP   = RUN_W'(V_BP * H_TOTAL);
    localparam logic [RUN_W-1:0] LEN_HSYNC = RUN_W'(H_SYNC);
    localparam logic [RUN_W-1:0] LEN_HBP   = RUN_W'(H_BP);
    localparam logic [RUN_W-1:0] LEN_HDATA = RUN_W'(H_VISIBLE);
    localparam logic [RUN_W-1:0] LEN_HFP   = RUN_W'(H_FP);
    localparam logic [RUN_W-1:0] LEN_VFP   = RUN_W'(H_FP + V_FP * H_TOTAL);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

    typedef enum logic [2:0] {
        S_SEARCH = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBP    = 3'd2,
        S_HSYNC  = 3'd3,
        S_HBP    = 3'd4,
        S_HDATA  = 3'd5,
        S_HFP    = 3'd6,
        S_VFP    = 3'd7
    } state_t;

    // Registered state
    state_t                   r_state;
    logic [RUN_W-1:0]         r_run;
    logic [LINE_W-1:0]        r_line;
    logic [31:0]              r_acc;
    logic                     r_vs_prev;
    logic                     r_locked;
    logic                     r_frame_done;
    logic [31:0]              r_frame_count;
    logic [31:0]              r_frame_checksum;
    logic [7:0]               r_err_flags;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    // Combinational decode
    logic                     w_hs_a;
    logic                     w_vs_a;
    logic                     w_multi;
    logic                     w_exit;
    logic                     w_wrong;
    state_t                   w_target;
    logic [RUN_W-1:0]         w_len_req;
    logic [7:0]               w_state_bit;
    logic [LINE_W-1:0]        w_line_inc;
    state_t                   w_state_next;
    logic [RUN_W-1:0]         w_run_next;
    logic [LINE_W-1:0]        w_line_next;
    logic [31:0]              w_acc_next;
    logic [7:0]               w_err_mask;
    logic                     w_err;
    logic                     w_frame_ok;

    // Sync strobes normalised to "asserted = 1" whatever the line polarity.
    assign w_hs_a     = (SYNC_POLARITY != 0) ? hsync : ~hsync;
    assign w_vs_a     = (SYNC_POLARITY != 0) ? vsync : ~vsync;
    assign w_multi    = (w_hs_a & w_vs_a) | (w_hs_a & de) | (w_vs_a & de);
    assign w_line_inc = r_line + LINE_W'(1);
    assign w_err      = (w_err_mask != 8'h00);

    // Per-state exit event, forbidden signals, successor, run length and error bit.
    always_comb begin
        w_exit      = 1'b0;
        w_wrong     = 1'b0;
        w_target    = S_SEARCH;
        w_len_req   = '0;
        w_state_bit = 8'h00;
        case (r_state)
            S_VSYNC: begin
                w_exit      = ~w_vs_a;
                w_target    = S_VBP;
                w_len_req   = LEN_VSYNC;
                w_state_bit = 8'h01;
            end
            S_VBP: begin
                w_exit      = w_hs_a;
                w_wrong     = w_vs_a | de;
                w_target    = S_HSYNC;
                w_len_req   = LEN_VBP;
                w_state_bit = 8'h02;
            end
            S_HSYNC: begin
                w_exit      = ~w_hs_a;
                w_target    = S_HBP;
                w_len_req   = LEN_HSYNC;
                w_state_bit = 8'h04;
            end
            S_HBP: begin
                w_exit      = de;
                w_wrong     = w_hs_a | w_vs_a;
                w_target    = S_HDATA;
                w_len_req   = LEN_HBP;
                w_state_bit = 8'h08;
            end
            S_HDATA: begin
                w_exit      = ~de;
                w_target    = (w_line_inc < LINE_W'(V_VISIBLE)) ? S_HFP : S_VFP;
                w_len_req   = LEN_HDATA;
                w_state_bit = 8'h10;
            end
            S_HFP: begin
                w_exit      = w_hs_a;
                w_wrong     = w_vs_a | de;
                w_target    = S_HSYNC;
                w_len_req   = LEN_HFP;
                w_state_bit = 8'h20;
            end
            S_VFP: begin
                w_exit      = w_vs_a;
                w_wrong     = w_hs_a | de;
                w_target    = S_VSYNC;
                w_len_req   = LEN_VFP;
                w_state_bit = 8'h40;
            end
            default: begin
                // SEARCH: wait for a fresh vsync leading edge.
                w_exit      = w_vs_a & ~r_vs_prev;
                w_target    = S_VSYNC;
            end
        endcase
    end

    // Next-state logic: length checks, error selection and pixel accumulation.
    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run + RUN_ONE;
        w_line_next  = r_line;
        w_acc_next   = r_acc;
        w_err_mask   = 8'h00;
        w_frame_ok   = 1'b0;

        if (r_state == S_SEARCH) begin
            if (w_exit) begin
                w_state_next = S_VSYNC;
                w_run_next   = RUN_ONE;
                w_line_next  = '0;
                w_acc_next   = '0;
            end
        end else if (w_exit) begin
            if (r_run == w_len_req) begin
                w_state_next = w_target;
                w_run_next   = RUN_ONE;
                if (r_state == S_HDATA) begin
                    w_line_next = w_line_inc;
                end
                if (r_state == S_VFP) begin
                    w_frame_ok  = 1'b1;
                    w_line_next = '0;
                    w_acc_next  = '0;
                end
            end else begin
                w_err_mask = w_state_bit;
            end
        end else if (w_wrong || (r_run >= w_len_req)) begin
            // Forbidden strobe in a gap state, or the state has been held too long.
            w_err_mask = w_state_bit;
        end

        // Overlapping strobes outrank any timing error in the same cycle.
        if (w_multi) begin
            w_err_mask = 8'h80;
        end

        if (w_err_mask != 8'h00) begin
            w_state_next = S_SEARCH;
            w_run_next   = RUN_ONE;
            w_line_next  = r_line;
            w_acc_next   = r_acc;
            w_frame_ok   = 1'b0;
        end

        // The cycle that raises de out of HBP is already the first data pixel.
        if ((w_state_next == S_HDATA) && de) begin
            w_acc_next = w_acc_next + 32'(pixel);
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_SEARCH;
            r_run            <= '0;
            r_line           <= '0;
            r_acc            <= '0;
            r_vs_prev        <= w_vs_a;
            r_locked         <= 1'b0;
            r_frame_done     <= 1'b0;
            r_frame_count    <= '0;
            r_frame_checksum <= '0;
            r_err_flags      <= '0;
            r_err_count      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_run        <= w_run_next;
            r_line       <= w_line_next;
            r_acc        <= w_acc_next;
            r_vs_prev    <= w_vs_a;
            r_frame_done <= w_frame_ok;
            if (w_frame_ok) begin
                r_locked         <= 1'b1;
                r_frame_count    <= r_frame_count + 32'd1;
                r_frame_checksum <= r_acc;
            end
            if (w_err) begin
                r_locked <= 1'b0;
                if (r_err_count != {ERR_CNT_WIDTH{1'b1}}) begin
                    r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
                end
            end
            // A clear and a new error in the same cycle leave the new bit set.
            r_err_flags <= (err_clear ? 8'h00 : r_err_flags) | w_err_mask;
        end
    end

    assign locked         = r_locked;
    assign frame_done     = r_frame_done;
    assign frame_count    = r_frame_count;
    assign frame_checksum = r_frame_checksum;
    assign err_flags      = r_err_flags;
    assign err_count      = r_err_count;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_video_timing_checker.sv
// Directed bench for video_timing_checker on a tiny 15x8 frame (120 clocks).
module tb_video_timing_checker;

  localparam int PW = 24;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          hsync = 1'b1;
  logic          vsync = 1'b1;
  logic          de = 1'b0;
  logic [PW-1:0] pixel = '0;
  logic          err_clear = 1'b0;
  logic          locked;
  logic          frame_done;
  logic [31:0]   frame_count;
  logic [31:0]   frame_checksum;
  logic [7:0]    err_flags;
  logic [1:0]    err_count;
  logic [2:0]    dbg_state;

  video_timing_checker #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POLARITY(0), .PIXEL_WIDTH(PW), .ERR_CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
    .pixel(pixel), .err_clear(err_clear), .locked(locked),
    .frame_done(frame_done), .frame_count(frame_count),
    .frame_checksum(frame_checksum), .err_flags(err_flags),
    .err_count(err_count), .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int done_bad = 0;
  int done_base = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // one cycle of raw stimulus; outputs are looked at 1 time unit after the edge
  task automatic apply_raw(input logic hs, input logic vs, input logic d,
                           input logic [PW-1:0] px, input logic clr);
    hsync = ~hs;
    vsync = ~vs;
    de = d;
    pixel = px;
    err_clear = clr;
    @(posedge clk);
    #1;
  endtask

  // frame template: vsync 0-29, VBP 30-44, lines at 45+15*l:
  // hsync +0..2, HBP +3..4, data +5..12 (pixel = column), then front porch
  // kind 1 stretches line-2 hsync to 4 cycles (p = 78)
  task automatic drive_cycles(input int kind, input int p0, input int p1);
    for (int p = p0; p <= p1; p++) begin
      logic hs, vs, d;
      logic [PW-1:0] px;
      int off;
      hs = 1'b0; vs = 1'b0; d = 1'b0; px = '0;
      if (p < 30) vs = 1'b1;
      else if (p >= 45 && p < 105) begin
        off = (p - 45) % 15;
        if (off < 3) hs = 1'b1;
        else if (off >= 5 && off < 13) begin
          d = 1'b1;
          px = PW'(off - 5);
        end
      end
      if (kind == 1 && p == 78) hs = 1'b1;
      apply_raw(hs, vs, d, px, 1'b0);
      if (frame_done) begin
        done_seen++;
        if (p != 0) done_bad++;
      end
    end
  endtask

  typedef struct {
    logic       hs;
    logic       vs;
    logic       d;
    logic       clr;
    logic [7:0] exp_flags;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // strobe-overlap table, applied in SEARCH right after a reset
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 2'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 2'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 2'd2};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 2'd2};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 2'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 2'd3};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 2'd3};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 2'd3};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 2'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 2'd3};

    // reset state
    rst = 1'b1;
    repeat (3) apply_raw(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", frame_count, 32'd0);
    check("rst_checksum", frame_checksum, 32'd0);
    check("rst_err_flags", 32'(err_flags), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    repeat (3) apply_raw(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // three clean frames: pulses at the 2nd and 3rd vsync
    drive_cycles(0, 0, 119);
    check("f1_no_done", 32'(done_seen), 32'd0);
    drive_cycles(0, 0, 119);
    drive_cycles(0, 0, 119);
    check("clean_done_pulses", 32'(done_seen), 32'd2);
    check("clean_frame_count", frame_count, 32'd2);
    check("clean_checksum", frame_checksum, 32'd112);
    check("clean_locked", 32'(locked), 32'd1);
    check("clean_err_flags", 32'(err_flags), 32'd0);
    check("clean_err_count", 32'(err_count), 32'd0);
    check("clean_state_vfp", 32'(dbg_state), 32'd7);

    // frame with a 4-cycle hsync on line 2
    drive_cycles(1, 0, 0);
    check("f4_done", 32'(frame_done), 32'd1);
    check("f4_frame_count", frame_count, 32'd3);
    drive_cycles(1, 1, 77);
    check("pre_err_flags", 32'(err_flags), 32'd0);
    check("pre_err_state_hsync", 32'(dbg_state), 32'd3);
    drive_cycles(1, 78, 78);
    check("hs_err_flags", 32'(err_flags), 32'h04);
    check("hs_err_count", 32'(err_count), 32'd1);
    check("hs_err_locked", 32'(locked), 32'd0);
    check("hs_err_state", 32'(dbg_state), 32'd0);
    drive_cycles(1, 79, 119);
    drive_cycles(0, 0, 0);
    check("relock_no_done", 32'(frame_done), 32'd0);
    drive_cycles(0, 1, 119);
    drive_cycles(0, 0, 0);
    check("relock_done", 32'(frame_done), 32'd1);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_count", frame_count, 32'd4);
    check("relock_checksum", frame_checksum, 32'd112);
    check("relock_flags_sticky", 32'(err_flags), 32'h04);

    // reset pulse in the middle of line-0 data
    drive_cycles(0, 1, 52);
    check("mid_state_hdata", 32'(dbg_state), 32'd5);
    rst = 1'b1;
    drive_cycles(0, 53, 53);
    rst = 1'b0;
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_count", frame_count, 32'd0);
    check("mid_rst_checksum", frame_checksum, 32'd0);
    check("mid_rst_flags", 32'(err_flags), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    done_base = done_seen;
    drive_cycles(0, 54, 119);
    drive_cycles(0, 0, 119);
    drive_cycles(0, 0, 0);
    check("post_rst_done_pulses", 32'(done_seen - done_base), 32'd1);
    check("post_rst_count", frame_count, 32'd1);
    check("post_rst_checksum", frame_checksum, 32'd112);
    check("post_rst_locked", 32'(locked), 32'd1);
    check("done_only_at_vsync", 32'(done_bad), 32'd0);

    // table: overlap errors, err_clear, counter saturation at 3
    rst = 1'b1;
    repeat (2) apply_raw(1'b0, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      apply_raw(vecs[i].hs, vecs[i].vs, vecs[i].d, 24'h5a5a5a, vecs[i].clr);
      check($sformatf("vec%0d_err_flags", i), 32'(err_flags), 32'(vecs[i].exp_flags));
      check($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_state", i), 32'(dbg_state), 32'd0);
      check($sformatf("vec%0d_locked", i), 32'(locked), 32'd0);
    end

    // early de in HBP together with err_clear: error bit survives the clear
    drive_cycles(0, 0, 48);
    check("hbp_state", 32'(dbg_state), 32'd4);
    check("hbp_pre_flags", 32'(err_flags), 32'h80);
    apply_raw(1'b0, 1'b0, 1'b1, 24'd0, 1'b1);
    check("hbp_err_flags", 32'(err_flags), 32'h08);
    check("hbp_err_count", 32'(err_count), 32'd3);
    check("hbp_err_state", 32'(dbg_state), 32'd0);
    apply_raw(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_checker.md
VIDEO_TIMING_CHECKER -- requirements
Module: video_timing_checker

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 1024, active pixels per line.
REQ-002 The block SHALL have parameters H_FP, H_SYNC and H_BP, defaults 24, 136 and 160, the horizontal front porch, sync and back porch in clocks; H_TOTAL is their sum with H_VISIBLE.
REQ-003 The block SHALL have parameter V_VISIBLE, default 768, active lines per frame.
REQ-004 The block SHALL have parameters V_FP, V_SYNC and V_BP, defaults 3, 6 and 29, in lines; V_TOTAL is their sum with V_VISIBLE.
REQ-005 The block SHALL have parameter SYNC_POLARITY, default 0: 0 means active-low hsync/vsync, 1 means active-high.
REQ-006 The block SHALL have parameter PIXEL_WIDTH, default 24, and parameter ERR_CNT_WIDTH, default 16.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all inputs are synchronous to it.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 The block SHALL have inputs hsync, vsync and de, 1 bit each: sync strobes (polarity per SYNC_POLARITY) and active-high data enable.
REQ-010 The block SHALL have input pixel, PIXEL_WIDTH bits: pixel data, valid when de=1.
REQ-011 The block SHALL have input err_clear, 1 bit: clears err_flags.
REQ-012 The block SHALL have outputs locked and frame_done, 1 bit each: one clean frame seen, and a 1-cycle clean-frame pulse.
REQ-013 The block SHALL have outputs frame_count (32 bits, clean frames) and frame_checksum (32 bits, pixel sum of the last clean frame).
REQ-014 The block SHALL have outputs err_flags (8 bits, sticky) and err_count (ERR_CNT_WIDTH bits, saturating).

Function
REQ-015 The block SHALL normalise hsync and vsync to active-high "asserted" (hs_a, vs_a) per SYNC_POLARITY; de asserted means de==1.
REQ-016 The FSM SHALL have states SEARCH, VSYNC, VBP, HSYNC, HBP, HDATA, HFP and VFP, one run counter (widths sized for V_TOTAL*H_TOTAL), a line counter, and a 32-bit checksum accumulator.
REQ-017 The run counter SHALL load 1 on state entry and SHALL increment each cycle the state is held.
REQ-018 In SEARCH, a vs_a rising edge (asserted now, not in the previous cycle) SHALL enter VSYNC and clear the line counter and the accumulator.
REQ-019 The FSM SHALL use these exit events and required run lengths: VSYNC exits on vs_a low, length V_SYNC*H_TOTAL -> VBP.
REQ-020 VBP SHALL exit on hs_a, length V_BP*H_TOTAL -> HSYNC.
REQ-021 HSYNC SHALL exit on hs_a low, length H_SYNC -> HBP.
REQ-022 HBP SHALL exit on de, length H_BP -> HDATA.
REQ-023 HDATA SHALL exit on de low, length H_VISIBLE, and SHALL increment the line counter; it goes to HFP if fewer than V_VISIBLE lines are done, else to VFP.
REQ-024 HFP SHALL exit on hs_a, length H_FP -> HSYNC.
REQ-025 VFP SHALL exit on vs_a, length H_FP+V_FP*H_TOTAL -> VSYNC.
REQ-026 Any exit with a wrong run length, a held state whose counter would exceed the required length, or a wrong signal asserting in a gap state SHALL set the state's error bit and go to SEARCH.
REQ-027 The error bit mapping SHALL be: VSYNC=0, VBP=1, HSYNC=2, HBP=3, HDATA=4, HFP=5, VFP=6.
REQ-028 Bit 7 SHALL flag any cycle with more than one of hs_a, vs_a, de asserted, in any state including SEARCH; such a cycle goes to SEARCH and takes priority over timing errors.
REQ-029 At most one error SHALL be recorded per cycle; each recorded error SHALL increment err_count, saturating at all-ones, and SHALL clear locked.
REQ-030 On a valid VFP exit, the block SHALL pulse frame_done for 1 cycle, set locked, increment frame_count (wrapping), copy the accumulator plus the current cycle's contribution (zero) to frame_checksum, clear the accumulator and line counter, and enter VSYNC (back-to-back frames).
REQ-031 Each HDATA-state cycle with de=1 SHALL add the zero-extended pixel to the accumulator, mod 2^32.
REQ-032 All outputs SHALL be registered and SHALL reflect an input sampled at clk edge k immediately after edge k.
REQ-033 err_clear SHALL zero err_flags only; an error in the same cycle SHALL win (its bit ends set); err_count SHALL be unaffected.

Reset
REQ-034 When rst=1 at a clk edge, the FSM SHALL enter SEARCH, and all counters, the accumulator and all outputs SHALL become 0, including mid-frame; the previous-vsync register SHALL load the current vs_a.

Verification
REQ-035 The bench SHALL use H_VISIBLE=8, H_FP=2, H_SYNC=3, H_BP=2, V_VISIBLE=4, V_FP=1, V_SYNC=2, V_BP=1, giving H_TOTAL=15 and a frame of 120 clocks.
REQ-036 Three back-to-back clean frames with pixel=column 0..7 -> frame_done at the 2nd and 3rd vsync, frame_count=2, frame_checksum=112, locked=1, err_flags=0.
REQ-037 A 4-cycle hsync on line 2 -> err_flags=0x04, err_count=1, locked=0 next cycle; the following clean frame re-locks.
REQ-038 de and hsync high together for 1 cycle -> err_flags=0x80 only, err_count=1.
REQ-039 rst pulsed for 1 cycle mid-HDATA -> all outputs 0; no frame_done until a vsync rising edge plus one full clean frame.
REQ-040 err_clear asserted in the same cycle as an HBP error -> err_flags=0x08 afterwards.
REQ-041 With ERR_CNT_WIDTH=2, 5 separate errors -> err_count=3.
